y86_exec_cc: RTL

Registered execute stage for the Y86-64 core: it consumes decoded operands, performs the 64-bit ALU operation, and maintains the condition-code register (ZF/SF/OF). It evaluates branch and conditional-move conditions and presents a one-deep registered result to the memory stage over a valid/ready handshake. It sits between decode and memory and builds on the standalone 64-bit ALU function units (add, sub, and, xor).

---
 rtl/y86_exec_cc.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/y86_exec_cc.sv
// y86_exec_cc: registered execute stage of the Y86-64 core.
//
// This stage takes the decoded operands and computes the 64-bit ALU result
// (add, sub, and, xor). It keeps the condition-code register {ZF, SF, OF}
// and evaluates the cmovXX/jXX conditions. The result sits in a one-deep
// output register that the memory stage drains over a valid/ready handshake.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   in_valid         decode presents an instruction
//   in_ready         stage can accept (!out_valid || out_ready)
//   icode, ifun      Y86 instruction and function codes
//   alu_a, alu_b     signed operands A and B
//   out_valid        registered result available
//   out_ready        memory stage accepts the result
//   val_e            registered ALU result
//   cnd              registered condition outcome
//   cc               current condition codes {ZF, SF, OF}
//   err              registered invalid-function flag for the held result
module y86_exec_cc #(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   icode,
    input  logic [3:0]   ifun,
    input  logic [W-1:0] alu_a,
    input  logic [W-1:0] alu_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] val_e,
    output logic         cnd,
    output logic [2:0]   cc,
    output logic         err
);

    localparam logic [3:0] ICmov = 4'h2;
    localparam logic [3:0] IOpq  = 4'h6;
    localparam logic [3:0] IJxx  = 4'h7;

    // Reset value of CC: ZF set, SF and OF clear.
    localparam logic [2:0] CcReset = 3'b100;

    logic         acc;

    logic [W-1:0] add_r;
    logic [W-1:0] sub_r;
    logic         add_of;
    logic         sub_of;

    logic         zf;
    logic         sf;
    logic         of;

    logic [W-1:0] res_d;
    logic         of_d;
    logic         cnd_d;
    logic         err_d;
    logic         cc_we;

    logic [W-1:0] val_e_q;
    logic         cnd_q;
    logic         err_q;
    logic         valid_q;
    logic [2:0]   cc_q;

    assign in_ready = !valid_q || out_ready;
    assign acc      = in_valid && in_ready;

    // Both candidate sums are always formed. The opcode only picks one.
    assign add_r  = alu_b + alu_a;
    assign sub_r  = alu_b - alu_a;
    assign add_of = (alu_a[W-1] == alu_b[W-1]) && (add_r[W-1] != alu_b[W-1]);
    assign sub_of = (alu_a[W-1] != alu_b[W-1]) && (sub_r[W-1] != alu_b[W-1]);

    // Conditions use the CC as it stands before this cycle's update.
    assign zf = cc_q[2];
    assign sf = cc_q[1];
    assign of = cc_q[0];

    always_comb begin
        res_d = add_r;
        of_d  = 1'b0;
        cnd_d = 1'b0;
        err_d = 1'b0;
        cc_we = 1'b0;

        if (icode == IOpq) begin
            cc_we = 1'b1;
            case (ifun)
                4'h0: begin
                    res_d = add_r;
                    of_d  = add_of;
                end
                4'h1: begin
                    res_d = sub_r;
                    of_d  = sub_of;
                end
                4'h2: res_d = alu_a & alu_b;
                4'h3: res_d = alu_a ^ alu_b;
                default: begin
                    // Unknown OPq: deliver a zero result flagged as an error.
                    // CC is left untouched.
                    res_d = '0;
                    err_d = 1'b1;
                    cc_we = 1'b0;
                end
            endcase
        end

        if ((icode == ICmov) || (icode == IJxx)) begin
            case (ifun)
                4'h0:    cnd_d = 1'b1;
                4'h1:    cnd_d = (sf ^ of) | zf;
                4'h2:    cnd_d = sf ^ of;
                4'h3:    cnd_d = zf;
                4'h4:    cnd_d = !zf;
                4'h5:    cnd_d = !(sf ^ of);
                4'h6:    cnd_d = !(sf ^ of) && !zf;
                default: begin
                    cnd_d = 1'b0;
                    err_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q <= CcReset;
        end else if (acc && cc_we) begin
            cc_q <= {(res_d == '0), res_d[W-1], of_d};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            val_e_q <= '0;
            cnd_q   <= 1'b0;
            err_q   <= 1'b0;
        end else if (acc) begin
            valid_q <= 1'b1;
            val_e_q <= res_d;
            cnd_q   <= cnd_d;
            err_q   <= err_d;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign val_e     = val_e_q;
    assign cnd       = cnd_q;
    assign err       = err_q;
    assign cc        = cc_q;

endmodule
